// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and the
// clocks-per-bit calculation reused by the transmitter and the future receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Rounded to the nearest whole clock so the bit period error stays under half a clock.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO in front of the UART shifter; pop data is the head word, valid while !empty.
// Push is refused while full, even if a pop happens the same cycle; full/empty are registered.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words sent LSB-first, frames back-to-back.
// First start bit drives one clock after the push; wr_ready deasserts while the FIFO is full.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_cfg: BAUD_DIV must be at least 2");
    end

    tx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [DATA_BITS-1:0] fifo_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic                 stop_done;

    assign wr_ready  = !fifo_full;
    assign push      = wr_valid && !fifo_full;
    assign baud_last = (baud_cnt == CW'(BAUD_DIV - 1));
    assign stop_done = (state == S_STOP) && baud_last && (bit_cnt == 4'(STOP_BITS - 1));
    // A new frame is fetched either from idle or straight off the last stop clock.
    assign pop       = !fifo_empty && ((state == S_IDLE) || stop_done);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (push) begin
                busy <= 1'b1;
            end else if (stop_done && fifo_empty) begin
                busy <= 1'b0;
            end

            if (pop) begin
                shift    <= fifo_dat;
                par_bit  <= (^fifo_dat) ^ (PARITY == PAR_ODD);
                baud_cnt <= '0;
                bit_cnt  <= '0;
                state    <= S_START;
                tx       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        tx <= 1'b1;
                    end
                    S_START: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= S_DATA;
                            tx       <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            shift    <= shift >> 1;
                            if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (PARITY != PAR_NONE) begin
                                    state <= S_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= S_STOP;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 4'(STOP_BITS - 1)) begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with configurable clock/baud, frame format (data bits, parity, stop bits) and a small input FIFO behind a valid/ready write port. Serialises queued words LSB-first onto a single idle-high line, back-to-back with no inter-frame gap. Drop-in replacement for the fixed 8N1 transmitter feeding the board UART pin. Adds flow control, so host logic can no longer overwrite a word mid-frame.

## Interface
- CLK_FREQ, 50000000: clk frequency in Hz.
- BAUD, 115200: line rate; BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit (434 at defaults).
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: words buffered, power of two, ≥2.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low; clock clk.
- wr_data  in  DATA_BITS  word to transmit.
- wr_valid  in  1  wr_data valid this cycle.
- wr_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued (excludes word being shifted).

## Operation
- Reset (async): tx=1, busy=0, wr_ready=1, fifo_count=0, FSM=IDLE, FIFO pointers cleared. Reset mid-frame aborts immediately. Line returns high; no partial frame is resumed.
- Push on wr_valid && wr_ready. When full, wr_ready=0 and wr_valid is ignored, even if a pop occurs the same cycle.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop into shift register, compute parity, clear bit counter and baud counter, go to START.
  - START: tx=0 for BAUD_DIV clocks, then go to DATA.
  - DATA: tx=shift[0] for BAUD_DIV clocks per bit. Shift right after each bit. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx = XOR of data bits (even) or its inverse (odd), for BAUD_DIV clocks, then go to STOP.
  - STOP: tx=1 for STOP_BITS×BAUD_DIV clocks. At the end, if FIFO non-empty, pop and go directly to START; else go to IDLE.
- Baud counter counts 0..BAUD_DIV-1. It restarts at every frame start and is not free-running.
- Elaboration error if DATA_BITS, PARITY, STOP_BITS or FIFO_DEPTH are out of range, or if BAUD_DIV<2.

## Timing
- Push at edge E into an empty FIFO with FSM in IDLE: pop at edge E+1, and tx=0 from edge E+1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV clocks exactly. No jitter; each bit lasts exactly BAUD_DIV clocks.
- Back-to-back frames: the start bit follows the last stop-bit clock with zero idle clocks.
- busy: rises at the push edge, and falls on the edge where the FSM enters IDLE with the FIFO empty.
- fifo_count: updates on the edge after a push/pop. A simultaneous push and pop leaves it unchanged.
- wr_ready: combinational from the registered full flag, with no dependence on wr_valid.

## Structure
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - constant function baud_div(clk_freq, baud), shared with the future receiver.
- One sub-module, uart_tx_fifo: synchronous FIFO, width DATA_BITS, depth FIFO_DEPTH, with full/empty/count outputs.
- Remaining FSM, baud counter and shifter live in uart_tx_cfg.

## Test plan
All scenarios use CLK_FREQ=1000000 and BAUD=100000 (BAUD_DIV=10) unless stated.
- 8N1, push 0x55 once → tx low 1 clk after push, then 10-clk bits 0,1,0,1,0,1,0,1,0,1. 100 clks total, then tx=1 and busy=0.
- 8E1, push 0x07 → parity bit 1 and 110-clk frame. Repeat with 8O1 → parity bit 0.
- 7N2, push 0x7F → 0, seven 1s, stop high 20 clks. Frame is 100 clks.
- Push 5 words (0x01..0x05) back-to-back at FIFO_DEPTH=4:
  - wr_ready drops once 4 words are queued while word 1 is shifting;
  - all 5 frames emerge contiguously with no idle clocks between stop and start, in order;
  - fifo_count tracks 4→0.
- Assert reset_n mid DATA bit 3 of 0xA5 with 2 words queued → tx=1 immediately and fifo_count=0. After release, no output until a new push; next push of 0x3C transmits cleanly.
- Defaults (50 MHz/115200) → each bit measures 434 clks.
